// File: rtl/mips_pkg.sv
// Shared definitions for the MEM pipeline stage: default widths, the
// handshake FSM state encoding and the bubble values loaded into the
// EX/MEM and MEM/WB pipeline registers.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Wait counter width; large enough for any TIMEOUT in 1..255.
  localparam int CNT_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Control bits carried in the EX/MEM register.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic branch;
    logic mem_read;
    logic mem_write;
  } ex_mem_ctrl_t;

  // Control bits carried in the MEM/WB register.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } mem_wb_ctrl_t;

  // A bubble has every control bit cleared so it can neither write the
  // register file nor start a memory access nor take a branch.
  localparam ex_mem_ctrl_t EX_MEM_CTRL_BUBBLE = '0;
  localparam mem_wb_ctrl_t MEM_WB_CTRL_BUBBLE = '0;
  localparam logic         ZERO_BUBBLE        = 1'b0;

  // True when the instruction in EX/MEM touches data memory.
  function automatic logic is_memop(input ex_mem_ctrl_t ctrl);
    return ctrl.mem_read | ctrl.mem_write;
  endfunction

endpackage

// File: rtl/mem_handshake_fsm.sv
// Request/ready handshake tracker for the data-memory port. Counts wait
// cycles while a request is outstanding, produces the pipeline stall and
// flags an abort when the memory fails to answer within TIMEOUT cycles.
module mem_handshake_fsm
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ready,
  output logic stall,
  output logic abort
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t           state_q;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic             timed_out;
  logic             complete;

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_next;
      cnt_q   <= cnt_next;
    end
  end

  // Next-state logic plus stall/abort decode. A ready arriving in the same
  // cycle as the timeout wins, so the access completes normally.
  always_comb begin
    state_next = state_q;
    cnt_next   = cnt_q;
    timed_out  = (state_q == WAIT) && (cnt_q == TIMEOUT_CNT);
    complete   = req & (ready | timed_out);
    stall      = req & ~complete;
    abort      = req & timed_out & ~ready;
    unique case (state_q)
      IDLE: begin
        if (req && !ready) begin
          state_next = WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (!req || ready || timed_out) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/stage_mem_access.sv
// MEM pipeline stage: EX/MEM register, branch resolution, data-memory
// request with variable latency, and the MEM/WB register feeding
// write-back. Upstream stages are frozen while an access is outstanding.
module stage_mem_access #(
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int REG_W   = mips_pkg::REG_W,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic              Branch_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic [DATA_W-1:0] ALUAddResult,
  input  logic              Zero,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic [REG_W-1:0]  WriteReg,
  input  logic              Flush,
  output logic              PCSrc,
  output logic [DATA_W-1:0] BranchTarget,
  output logic              Stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic [DATA_W-1:0] ReadData_out,
  output logic [DATA_W-1:0] ALUResult_out,
  output logic [REG_W-1:0]  WriteReg_out,
  output logic              MemErr
);

  import mips_pkg::*;

  // EX/MEM register contents
  ex_mem_ctrl_t      exm_ctrl_q;
  logic [DATA_W-1:0] alu_add_q;
  logic              zero_q;
  logic [DATA_W-1:0] alu_result_q;
  logic [DATA_W-1:0] read_data2_q;
  logic [REG_W-1:0]  write_reg_q;

  // MEM/WB register contents
  mem_wb_ctrl_t      wb_ctrl_q;
  logic [DATA_W-1:0] wb_read_data_q;
  logic [DATA_W-1:0] wb_alu_result_q;
  logic [REG_W-1:0]  wb_write_reg_q;

  logic              mem_err_q;
  logic              done_q;
  logic              memop_q;
  logic              abort;
  logic              load_hit;

  // Reserved for a multi-beat mode; single-beat accesses never set it.
  assign done_q  = 1'b0;

  assign memop_q = is_memop(exm_ctrl_q);
  assign mem_req = memop_q & ~done_q;
  assign mem_we  = exm_ctrl_q.mem_write;

  // Address and store data come straight from EX/MEM, which is frozen by
  // Stall, so they stay stable for the whole request.
  assign mem_addr  = alu_result_q;
  assign mem_wdata = read_data2_q;

  assign PCSrc        = exm_ctrl_q.branch & zero_q;
  assign BranchTarget = alu_add_q;

  // Read data is only meaningful when our own load completes this cycle.
  assign load_hit = exm_ctrl_q.mem_read & mem_req & mem_ready;

  mem_handshake_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_handshake (
    .clk   (Clk),
    .rst_n (Rst),
    .req   (mem_req),
    .ready (mem_ready),
    .stall (Stall),
    .abort (abort)
  );

  // EX/MEM register: capture, load a bubble on Flush, or hold while stalled.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      exm_ctrl_q   <= EX_MEM_CTRL_BUBBLE;
      alu_add_q    <= '0;
      zero_q       <= ZERO_BUBBLE;
      alu_result_q <= '0;
      read_data2_q <= '0;
      write_reg_q  <= '0;
    end else if (!Stall) begin
      if (Flush) begin
        exm_ctrl_q   <= EX_MEM_CTRL_BUBBLE;
        alu_add_q    <= '0;
        zero_q       <= ZERO_BUBBLE;
        alu_result_q <= '0;
        read_data2_q <= '0;
        write_reg_q  <= '0;
      end else begin
        exm_ctrl_q.reg_write  <= RegWrite_in;
        exm_ctrl_q.mem_to_reg <= MemtoReg_in;
        exm_ctrl_q.branch     <= Branch_in;
        exm_ctrl_q.mem_read   <= MemRead_in;
        exm_ctrl_q.mem_write  <= MemWrite_in;
        alu_add_q             <= ALUAddResult;
        zero_q                <= Zero;
        alu_result_q          <= ALUResult;
        read_data2_q          <= ReadData2;
        write_reg_q           <= WriteReg;
      end
    end
  end

  // MEM/WB register: retire the EX/MEM instruction, or insert a bubble
  // for every cycle the access is still outstanding.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wb_ctrl_q       <= MEM_WB_CTRL_BUBBLE;
      wb_read_data_q  <= '0;
      wb_alu_result_q <= '0;
      wb_write_reg_q  <= '0;
    end else if (Stall) begin
      wb_ctrl_q       <= MEM_WB_CTRL_BUBBLE;
      wb_read_data_q  <= '0;
      wb_alu_result_q <= '0;
      wb_write_reg_q  <= '0;
    end else begin
      wb_ctrl_q.reg_write  <= exm_ctrl_q.reg_write & ~abort;
      wb_ctrl_q.mem_to_reg <= exm_ctrl_q.mem_to_reg;
      wb_read_data_q       <= load_hit ? mem_rdata : '0;
      wb_alu_result_q      <= alu_result_q;
      wb_write_reg_q       <= write_reg_q;
    end
  end

  // Sticky error flag recording any timed-out access since reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mem_err_q <= 1'b0;
    end else if (abort) begin
      mem_err_q <= 1'b1;
    end
  end

  assign RegWrite_out  = wb_ctrl_q.reg_write;
  assign MemtoReg_out  = wb_ctrl_q.mem_to_reg;
  assign ReadData_out  = wb_read_data_q;
  assign ALUResult_out = wb_alu_result_q;
  assign WriteReg_out  = wb_write_reg_q;
  assign MemErr        = mem_err_q;

endmodule

// File: tb/tb_stage_mem_access.sv
// Scoreboard bench for stage_mem_access: the stimulus pushes each
// instruction's expected MEM/WB retire record into a queue, and a monitor
// pops and compares whenever a non-bubble record appears on MEM/WB.
module tb_stage_mem_access;

  logic        Clk;
  logic        Rst;
  logic        RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in;
  logic [31:0] ALUAddResult;
  logic        Zero;
  logic [31:0] ALUResult;
  logic [31:0] ReadData2;
  logic [4:0]  WriteReg;
  logic        Flush;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic        Stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        RegWrite_out, MemtoReg_out;
  logic [31:0] ReadData_out, ALUResult_out;
  logic [4:0]  WriteReg_out;
  logic        MemErr;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  passes = 0;

  stage_mem_access #(
    .DATA_W  (32),
    .REG_W   (5),
    .TIMEOUT (15)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .RegWrite_in   (RegWrite_in),
    .MemtoReg_in   (MemtoReg_in),
    .Branch_in     (Branch_in),
    .MemRead_in    (MemRead_in),
    .MemWrite_in   (MemWrite_in),
    .ALUAddResult  (ALUAddResult),
    .Zero          (Zero),
    .ALUResult     (ALUResult),
    .ReadData2     (ReadData2),
    .WriteReg      (WriteReg),
    .Flush         (Flush),
    .PCSrc         (PCSrc),
    .BranchTarget  (BranchTarget),
    .Stall         (Stall),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .RegWrite_out  (RegWrite_out),
    .MemtoReg_out  (MemtoReg_out),
    .ReadData_out  (ReadData_out),
    .ALUResult_out (ALUResult_out),
    .WriteReg_out  (WriteReg_out),
    .MemErr        (MemErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      passes++;
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic drive_ex(input logic rw, input logic m2r, input logic br,
                          input logic mr, input logic mw, input logic [31:0] add,
                          input logic z, input logic [31:0] alu,
                          input logic [31:0] rd2, input logic [4:0] wr);
    RegWrite_in  = rw;
    MemtoReg_in  = m2r;
    Branch_in    = br;
    MemRead_in   = mr;
    MemWrite_in  = mw;
    ALUAddResult = add;
    Zero         = z;
    ALUResult    = alu;
    ReadData2    = rd2;
    WriteReg     = wr;
  endtask

  task automatic nop();
    drive_ex(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic push(input logic rw, input logic m2r, input logic [31:0] rd,
                      input logic [31:0] alu, input logic [4:0] wr);
    wb_t e;
    e.rw = rw; e.m2r = m2r; e.rd = rd; e.alu = alu; e.wr = wr;
    exp_q.push_back(e);
  endtask

  // Monitor: every non-bubble MEM/WB record must match the oldest expectation.
  always @(negedge Clk) begin
    wb_t act;
    wb_t e;
    act = {RegWrite_out, MemtoReg_out, ReadData_out, ALUResult_out, WriteReg_out};
    if (Rst === 1'b1 && act != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_retire", 128'(act), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check("retire", 128'(act), 128'(e));
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    Rst = 1'b0;
    Flush = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    nop();

    // Reset state
    @(negedge Clk); #1;
    check("rst_stall", 128'(Stall), 128'(0));
    check("rst_mem_req", 128'(mem_req), 128'(0));
    check("rst_pcsrc", 128'(PCSrc), 128'(0));
    check("rst_memerr", 128'(MemErr), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    // Zero-wait load
    drive_ex(1, 1, 0, 1, 0, 32'h0, 0, 32'h40, 32'h0, 5'd5);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    push(1, 1, 32'hDEADBEEF, 32'h40, 5'd5);
    @(negedge Clk);
    nop(); #1;
    check("zw_mem_req", 128'(mem_req), 128'(1));
    check("zw_stall", 128'(Stall), 128'(0));
    check("zw_mem_addr", 128'(mem_addr), 128'(32'h40));
    check("zw_mem_we", 128'(mem_we), 128'(0));
    @(negedge Clk);
    mem_ready = 1'b0;

    // ALU op with stray ready and read data that must be ignored
    drive_ex(1, 0, 0, 0, 0, 32'h0, 0, 32'h55, 32'h0, 5'd3);
    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    push(1, 0, 32'h0, 32'h55, 5'd3);
    @(negedge Clk);
    nop(); #1;
    check("alu_mem_req", 128'(mem_req), 128'(0));
    check("alu_stall", 128'(Stall), 128'(0));
    @(negedge Clk);
    mem_ready = 1'b0;

    // 3-wait store
    drive_ex(0, 0, 0, 0, 1, 32'h0, 0, 32'h80, 32'h1234, 5'd7);
    push(0, 0, 32'h0, 32'h80, 5'd7);
    @(negedge Clk);
    nop();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      if (Stall) n++;
      check("st_mem_req", 128'(mem_req), 128'(1));
      check("st_mem_we", 128'(mem_we), 128'(1));
      check("st_mem_addr", 128'(mem_addr), 128'(32'h80));
      check("st_mem_wdata", 128'(mem_wdata), 128'(32'h1234));
      @(negedge Clk);
    end
    mem_ready = 1'b0;
    check("st_stall_cycles", 128'(n), 128'(3));

    // Branch taken then not taken
    drive_ex(0, 0, 1, 0, 0, 32'h100, 1, 32'h3, 32'h0, 5'd0);
    push(0, 0, 32'h0, 32'h3, 5'd0);
    @(negedge Clk);
    drive_ex(0, 0, 1, 0, 0, 32'h200, 0, 32'h5, 32'h0, 5'd0);
    push(0, 0, 32'h0, 32'h5, 5'd0);
    #1;
    check("br_taken_pcsrc", 128'(PCSrc), 128'(1));
    check("br_taken_target", 128'(BranchTarget), 128'(32'h100));
    @(negedge Clk);
    nop(); #1;
    check("br_nt_pcsrc", 128'(PCSrc), 128'(0));
    check("br_nt_target", 128'(BranchTarget), 128'(32'h200));
    @(negedge Clk);

    // Timeout abort on a load
    check("pre_to_memerr", 128'(MemErr), 128'(0));
    drive_ex(1, 1, 0, 1, 0, 32'h0, 0, 32'h44, 32'h0, 5'd9);
    push(0, 1, 32'h0, 32'h44, 5'd9);
    @(negedge Clk);
    nop();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!Stall) break;
      n++;
      @(negedge Clk);
    end
    check("to_stall_cycles", 128'(n), 128'(15));
    check("to_mem_req_final", 128'(mem_req), 128'(1));
    check("to_memerr_before", 128'(MemErr), 128'(0));
    @(negedge Clk); #1;
    check("to_memerr_set", 128'(MemErr), 128'(1));
    @(negedge Clk);

    // Flush while stalled: ignored until the stall clears
    drive_ex(1, 1, 0, 1, 0, 32'h0, 0, 32'h60, 32'h0, 5'd4);
    push(1, 1, 32'hCAFEF00D, 32'h60, 5'd4);
    @(negedge Clk);
    Flush = 1'b1;
    drive_ex(1, 0, 0, 0, 0, 32'h0, 0, 32'h77, 32'h0, 5'd2);
    #1;
    check("fl_stall", 128'(Stall), 128'(1));
    @(negedge Clk); #1;
    check("fl_hold_addr", 128'(mem_addr), 128'(32'h60));
    check("fl_hold_req", 128'(mem_req), 128'(1));
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1;
    check("fl_stall_release", 128'(Stall), 128'(0));
    @(negedge Clk);
    Flush = 1'b0;
    mem_ready = 1'b0;
    nop(); #1;
    check("fl_bubble_req", 128'(mem_req), 128'(0));
    check("fl_bubble_addr", 128'(mem_addr), 128'(0));
    check("memerr_sticky", 128'(MemErr), 128'(1));
    @(negedge Clk);

    // Reset in the middle of a wait
    drive_ex(1, 0, 0, 1, 0, 32'h0, 0, 32'h90, 32'h0, 5'd6);
    @(negedge Clk);
    nop();
    @(negedge Clk); #1;
    check("mr_stall_before", 128'(Stall), 128'(1));
    Rst = 1'b0;
    #1;
    check("mr_stall", 128'(Stall), 128'(0));
    check("mr_mem_req", 128'(mem_req), 128'(0));
    check("mr_mem_addr", 128'(mem_addr), 128'(0));
    check("mr_memerr", 128'(MemErr), 128'(0));
    check("mr_regwrite_out", 128'(RegWrite_out), 128'(0));
    check("mr_alu_out", 128'(ALUResult_out), 128'(0));
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    // Normal operation resumes after reset
    drive_ex(1, 0, 0, 0, 0, 32'h0, 0, 32'h66, 32'h0, 5'd8);
    push(1, 0, 32'h0, 32'h66, 5'd8);
    @(negedge Clk);
    nop(); #1;
    check("post_rst_stall", 128'(Stall), 128'(0));
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk); #1;
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/stage_mem_access.md
# stage_mem_access

Consumer end of the EX-stage output bundle. Registers the EX results into the EX/MEM pipeline register and resolves the branch (PCSrc, target). Drives a variable-latency data-memory request/ready handshake and stalls upstream stages while an access is outstanding. Feeds the MEM/WB register that goes to write-back.

## Interface

Parameters:

- DATA_W, 32, datapath width
- REG_W, 5, register-specifier width
- TIMEOUT, 15, max wait cycles for mem_ready before abort; 1..255

Ports. Clock and reset come first; reset is asynchronous and active-low.

- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in  in  1 each  EX control bits
- ALUAddResult  in  DATA_W  branch target from EX
- Zero  in  1  ALU zero flag
- ALUResult  in  DATA_W  ALU result / memory address
- ReadData2  in  DATA_W  store data
- WriteReg  in  REG_W  destination register (RegDst mux output)
- Flush  in  1  load a bubble into EX/MEM
- PCSrc  out  1  Branch_q & Zero_q
- BranchTarget  out  DATA_W  ALUAddResult_q
- Stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- mem_req  out  1  access request
- mem_we  out  1  1 = write
- mem_addr, mem_wdata  out  DATA_W  ALUResult_q, ReadData2_q
- mem_ready  in  1  access complete this cycle
- mem_rdata  in  DATA_W  valid when mem_ready & !mem_we
- RegWrite_out, MemtoReg_out  out  1  MEM/WB controls
- ReadData_out, ALUResult_out  out  DATA_W  MEM/WB data
- WriteReg_out  out  REG_W  MEM/WB destination
- MemErr  out  1  sticky; set on timeout abort

## Operation

**EX/MEM register**
- On each edge with Stall=0 it captures all *_in, the data inputs and WriteReg.
- If Flush=1 (and Stall=0) it captures a bubble: all control bits 0, data fields 0.
- With Stall=1 it holds. Flush is ignored; the requester must hold Flush until Stall=0.

**Memory access**
- memop_q = MemRead_q | MemWrite_q.
- mem_req = memop_q & !done_q, combinational. It is never asserted for a bubble.
- mem_we = MemWrite_q.
- Completion is mem_ready=1 while mem_req=1, or the wait counter reaching TIMEOUT.
- Stall = mem_req & !completion. A zero-wait memory (ready in the request cycle) causes no stall.

**FSM**
- IDLE: with mem_req & !mem_ready, go to WAIT and set cnt=1. Otherwise stay.
- WAIT: cnt increments each cycle.
  - mem_ready → IDLE.
  - cnt==TIMEOUT → IDLE (abort).
- done_q is unused by the core path. It stays 0 and is reserved for a future multi-beat mode.
- mem_addr, mem_we and mem_wdata stay stable for the whole request.

**MEM/WB register**
- On an edge with Stall=0 it captures:
  - RegWrite_q, forced to 0 on abort
  - MemtoReg_q
  - ReadData_out = mem_rdata if MemRead_q & mem_ready, else 0
  - ALUResult_q
  - WriteReg_q
- On an edge with Stall=1 it loads a bubble: RegWrite_out=0, all other fields 0.

**Abort**
- Sets MemErr (sticky until reset).
- The instruction retires with no register write.

**Branch**
- PCSrc and BranchTarget are combinational from EX/MEM register contents.
- Branch instructions never carry memop, so PCSrc and Stall cannot come from the same instruction.

## Timing

- Reset (Rst=0, asynchronous):
  - every register cleared; state=IDLE, cnt=0, MemErr=0
  - outputs: PCSrc=0, BranchTarget=0, Stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all MEM/WB outputs 0
- Reset in WAIT abandons the access with no further handshake.
- Latency: EX input at edge N appears in EX/MEM after N and in MEM/WB after N+1+w, where w is the number of stall cycles.
- Stall is asserted combinationally in the cycle mem_req rises if mem_ready=0.
- Stall deasserts in the cycle mem_ready=1 or cnt==TIMEOUT.
- A timeout abort costs exactly TIMEOUT stall cycles.
- mem_ready while mem_req=0 is ignored.

## Structure

- Shared package mips_pkg holds:
  - DATA_W, REG_W
  - the FSM state encoding (IDLE=0, WAIT=1)
  - the bubble-constant values for the EX/MEM and MEM/WB fields
- One natural sub-module, mem_handshake_fsm, owns state, cnt, Stall and abort.
- Both pipeline registers stay in the top.

## Test plan

- **Reset:** assert Rst=0 mid-WAIT → all outputs 0 immediately; Stall=0; MemErr=0.
- **Zero-wait load:** MemRead with ALUResult=0x40, mem_ready=1 in the same cycle, mem_rdata=0xDEADBEEF → Stall never 1; next cycle ReadData_out=0xDEADBEEF, RegWrite_out=1.
- **3-wait store:** MemWrite with addr 0x80, wdata 0x1234, mem_ready rising on the 4th request cycle → Stall=1 for 3 cycles; addr and wdata stable; MEM/WB shows 3 bubbles then the store.
- **Timeout:** mem_ready held at 0, TIMEOUT=15 → 15 stall cycles; retired RegWrite_out=0; MemErr=1 and stays 1.
- **Branch:** Branch_in=1, Zero=1, ALUAddResult=0x100 → next cycle PCSrc=1, BranchTarget=0x100. With Zero=0 → PCSrc=0.
- **Flush during stall:** Flush=1 while Stall=1 → EX/MEM unchanged; Flush held until Stall=0 → bubble loaded, mem_req=0.
